master_reset_classifier: RTL and testbench
==========================================

# master_reset_classifier

Parametrised classifier for the reset line driven by the master. It synchronises the asynchronous `rst_from_master` input, measures each high pulse in clock cycles, and rejects glitches. Each valid pulse is classified as short or long, and the block issues a fixed-width `short_reset` or `long_reset` pulse, followed by a programmable holdoff. Stuck-high detection and optional event counters are included. It sits between the master-link input pin and the local reset distribution.

## Interface
- `SYNC_STAGES`, default 2: synchroniser flops on `rst_from_master` (≥2).
- `MIN_WIDTH`, default 2: pulses shorter than this many cycles are glitches.
- `SHORT_MAX`, default 5: widths MIN_WIDTH..SHORT_MAX are short; wider pulses are long.
- `STUCK_MAX`, default 1000: width at which the input is declared stuck.
- `OUT_WIDTH`, default 4: output pulse width in cycles (≥1).
- `HOLDOFF`, default 8: lockout cycles after each output pulse (0 allowed).
- `CNT_W`, derived: $clog2(STUCK_MAX+1).
- `clk`  in  1  sampling clock
- `rst`  in  1  synchronous, active-high reset; clock `clk`
- `rst_from_master`  in  1  asynchronous reset request from master
- `cnt_clr`  in  1  synchronous clear of event counters
- `short_reset`  out  1  registered short-reset pulse
- `long_reset`  out  1  registered long-reset pulse, also held while stuck
- `stuck`  out  1  input high for ≥STUCK_MAX cycles
- `busy`  out  1  FSM not in IDLE
- `last_width`  out  CNT_W  width of the most recently classified pulse
- `short_count`, `long_count`, `glitch_count`  out  16 each  saturating event counters

## Operation
- The parameter constraint 1 ≤ MIN_WIDTH ≤ SHORT_MAX < STUCK_MAX is checked at elaboration.
- `s_in` is the synchronised input. The FSM has the states IDLE, MEASURE, PULSE_S, PULSE_L, STUCK, HOLDOFF and WAIT_LOW.
- **IDLE:** when `s_in`=1, go to MEASURE with `cnt`=1.
- **MEASURE:** while `s_in`=1, `cnt`++. When `cnt` reaches STUCK_MAX, go to STUCK.
- **MEASURE, `s_in`=0:** latch `last_width`=`cnt`, then branch:
  - `cnt` < MIN_WIDTH: count a glitch and return to IDLE.
  - `cnt` ≤ SHORT_MAX: go to PULSE_S.
  - otherwise: go to PULSE_L.
- **STUCK:** `stuck`=1 and `long_reset`=1. When `s_in`=0, latch `last_width`=STUCK_MAX and go to PULSE_L.
- **PULSE_S / PULSE_L:** hold the output for OUT_WIDTH cycles and ignore `s_in`. Then go to HOLDOFF, or skip it if HOLDOFF=0.
- **HOLDOFF:** wait HOLDOFF cycles. At the end, go to WAIT_LOW if `s_in`=1, else IDLE.
- **WAIT_LOW:** wait for `s_in`=0, then go to IDLE. A pulse that starts during a pulse or holdoff is never classified.
- **Counters:**
  - Each counter increments on entry to PULSE_S, PULSE_L (from MEASURE or STUCK) or on a glitch decision.
  - Counters saturate at 16'hFFFF.
  - `cnt_clr` zeroes them; `cnt_clr` wins over a same-cycle increment.
- `rst` overrides everything, mid-pulse included.

## Timing
- Reset values: all outputs 0, FSM in IDLE, synchroniser flops 0.
- Input-to-FSM latency is SYNC_STAGES cycles. Width is measured in synchronised cycles, accurate to ±1 cycle of raw input.
- The output asserts on the cycle after the clock edge at which MEASURE sees `s_in`=0. It stays high for exactly OUT_WIDTH cycles.
- A stuck input gives `long_reset` high from the STUCK entry cycle through release, plus OUT_WIDTH further cycles, with no gap.
- `stuck` deasserts on the same edge that PULSE_L begins.
- `short_reset` and `long_reset` are never high in the same cycle.
- `busy` is registered and equals (state ≠ IDLE).

## Configuration
- `MASTER_RESET_COUNTERS_EN` defined: `short_count`, `long_count` and `glitch_count` are implemented as above.
- Macro undefined: the counter registers are not built, the three ports are tied to 0, and `cnt_clr` is ignored. All other behaviour is unchanged.

## Structure
- Shared package `master_reset_pkg`:
  - state encodings, one-hot, 7 bits;
  - default threshold constants (MIN_WIDTH, SHORT_MAX, STUCK_MAX, OUT_WIDTH, HOLDOFF);
  - counter width 16.
- One sub-module, `sync_chain`: a parametrised SYNC_STAGES flop synchroniser with reset to 0.
- The FSM, width counter, output timer and event counters stay in the top module.

## Test plan
All scenarios use the default parameters.
- Raw 1-cycle pulse: no output; `glitch_count`=1, `busy` returns to 0.
- 4-cycle pulse: `short_reset` is high for exactly 4 cycles starting SYNC_STAGES+1 cycles after the falling edge; `last_width`=4, `short_count`=1.
- 20-cycle pulse: `long_reset` is high for 4 cycles after release, `short_reset` is never high; `long_count`=1.
- Input held high for 1500 cycles: `stuck` and `long_reset` rise after 1000 synced cycles. On release, `long_reset` stays high for 4 more cycles and `stuck` drops.
- Second 4-cycle pulse starting 3 cycles after the first `short_reset` ends (inside HOLDOFF): no second output, and the FSM passes through WAIT_LOW. A 4-cycle pulse after IDLE is reached is classified short.
- `rst` asserted mid-PULSE_L, and `cnt_clr` coinciding with a short decision: all outputs are 0 the next cycle, and the counters read 0.

Source files
------------

// File: rtl/master_reset_pkg.sv
// Shared definitions for the master reset classifier: one-hot FSM state encodings,
// default thresholds, event counter width and a saturating increment helper.
package master_reset_pkg;

    // One-hot state encodings (7 states, 7 bits)
    localparam logic [6:0] StIdle    = 7'b000_0001;
    localparam logic [6:0] StMeasure = 7'b000_0010;
    localparam logic [6:0] StPulseS  = 7'b000_0100;
    localparam logic [6:0] StPulseL  = 7'b000_1000;
    localparam logic [6:0] StStuck   = 7'b001_0000;
    localparam logic [6:0] StHoldoff = 7'b010_0000;
    localparam logic [6:0] StWaitLow = 7'b100_0000;

    // Default thresholds
    localparam int unsigned DefSyncStages = 2;
    localparam int unsigned DefMinWidth   = 2;
    localparam int unsigned DefShortMax   = 5;
    localparam int unsigned DefStuckMax   = 1000;
    localparam int unsigned DefOutWidth   = 4;
    localparam int unsigned DefHoldoff    = 8;

    // Event counter width
    localparam int unsigned CntWidth = 16;

    // Increment by one when enabled, sticking at all-ones
    function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] val,
                                                    input logic                en);
        return (en && (val != '1)) ? val + 1'b1 : val;
    endfunction

endpackage

// File: rtl/master_reset_classifier_sync_chain.sv
// Multi-flop synchroniser for an asynchronous single-bit input; all stages clear to 0
// on the synchronous active-high reset.
module sync_chain #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;

    // Shift the raw input one stage further each cycle
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    end

    // Synchroniser flops
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/master_reset_classifier.sv
// Classifies high pulses on the master reset line as glitch, short or long, emits a
// fixed-width short_reset/long_reset pulse followed by a holdoff, and flags a stuck input.
// Build option MASTER_RESET_COUNTERS_EN adds saturating short/long/glitch event counters;
// without it the counter ports read 0 and cnt_clr is ignored.
module master_reset_classifier
    import master_reset_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DefSyncStages,
    parameter int unsigned MIN_WIDTH   = DefMinWidth,
    parameter int unsigned SHORT_MAX   = DefShortMax,
    parameter int unsigned STUCK_MAX   = DefStuckMax,
    parameter int unsigned OUT_WIDTH   = DefOutWidth,
    parameter int unsigned HOLDOFF     = DefHoldoff,
    localparam int unsigned CNT_W      = $clog2(STUCK_MAX + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rst_from_master,
    input  logic                cnt_clr,
    output logic                short_reset,
    output logic                long_reset,
    output logic                stuck,
    output logic                busy,
    output logic [CNT_W-1:0]    last_width,
    output logic [CntWidth-1:0] short_count,
    output logic [CntWidth-1:0] long_count,
    output logic [CntWidth-1:0] glitch_count
);

    // One timer serves both the output pulse and the holdoff
    localparam int unsigned TmrMax = (OUT_WIDTH > HOLDOFF) ? OUT_WIDTH : HOLDOFF;
    localparam int unsigned TmrW   = $clog2(TmrMax + 1);

    if (!(MIN_WIDTH >= 1 && MIN_WIDTH <= SHORT_MAX && SHORT_MAX < STUCK_MAX)) begin : gen_thr_err
        $error("master_reset_classifier: need 1 <= MIN_WIDTH <= SHORT_MAX < STUCK_MAX");
    end
    if (SYNC_STAGES < 2 || OUT_WIDTH < 1) begin : gen_cfg_err
        $error("master_reset_classifier: need SYNC_STAGES >= 2 and OUT_WIDTH >= 1");
    end

    logic             s_in;
    logic [6:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TmrW-1:0]  tmr_q, tmr_d;
    logic [CNT_W-1:0] last_width_q, last_width_d;
    logic             short_reset_q, long_reset_q, stuck_q, busy_q;
    logic             inc_short, inc_long, inc_glitch;

    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d_i(rst_from_master),
        .q_o(s_in)
    );

    // Next-state logic: pulse measurement, classification and output/holdoff timing
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tmr_d        = tmr_q;
        last_width_d = last_width_q;
        inc_short    = 1'b0;
        inc_long     = 1'b0;
        inc_glitch   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (s_in) begin
                    state_d = StMeasure;
                    cnt_d   = CNT_W'(1);
                end
            end
            StMeasure: begin
                if (s_in) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_W'(STUCK_MAX)) begin
                        state_d = StStuck;
                    end
                end else begin
                    last_width_d = cnt_q;
                    if (cnt_q < CNT_W'(MIN_WIDTH)) begin
                        state_d    = StIdle;
                        inc_glitch = 1'b1;
                    end else if (cnt_q <= CNT_W'(SHORT_MAX)) begin
                        state_d   = StPulseS;
                        tmr_d     = TmrW'(OUT_WIDTH - 1);
                        inc_short = 1'b1;
                    end else begin
                        state_d  = StPulseL;
                        tmr_d    = TmrW'(OUT_WIDTH - 1);
                        inc_long = 1'b1;
                    end
                end
            end
            StStuck: begin
                if (!s_in) begin
                    state_d      = StPulseL;
                    tmr_d        = TmrW'(OUT_WIDTH - 1);
                    last_width_d = CNT_W'(STUCK_MAX);
                    inc_long     = 1'b1;
                end
            end
            StPulseS, StPulseL: begin
                if (tmr_q == '0) begin
                    if (HOLDOFF != 0) begin
                        state_d = StHoldoff;
                        tmr_d   = TmrW'(HOLDOFF - 1);
                    end else begin
                        state_d = s_in ? StWaitLow : StIdle;
                    end
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            StHoldoff: begin
                if (tmr_q == '0) begin
                    state_d = s_in ? StWaitLow : StIdle;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            StWaitLow: begin
                if (!s_in) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, timers and registered outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            tmr_q         <= '0;
            last_width_q  <= '0;
            short_reset_q <= 1'b0;
            long_reset_q  <= 1'b0;
            stuck_q       <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tmr_q         <= tmr_d;
            last_width_q  <= last_width_d;
            short_reset_q <= (state_d == StPulseS);
            long_reset_q  <= (state_d == StPulseL) || (state_d == StStuck);
            stuck_q       <= (state_d == StStuck);
            busy_q        <= (state_d != StIdle);
        end
    end

    assign short_reset = short_reset_q;
    assign long_reset  = long_reset_q;
    assign stuck       = stuck_q;
    assign busy        = busy_q;
    assign last_width  = last_width_q;

`ifdef MASTER_RESET_COUNTERS_EN
    logic [CntWidth-1:0] short_count_q, short_count_d;
    logic [CntWidth-1:0] long_count_q, long_count_d;
    logic [CntWidth-1:0] glitch_count_q, glitch_count_d;

    // Saturating event counts; a clear beats a same-cycle increment
    always_comb begin
        short_count_d  = sat_inc(short_count_q, inc_short);
        long_count_d   = sat_inc(long_count_q, inc_long);
        glitch_count_d = sat_inc(glitch_count_q, inc_glitch);
        if (cnt_clr) begin
            short_count_d  = '0;
            long_count_d   = '0;
            glitch_count_d = '0;
        end
    end

    // Event counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            short_count_q  <= '0;
            long_count_q   <= '0;
            glitch_count_q <= '0;
        end else begin
            short_count_q  <= short_count_d;
            long_count_q   <= long_count_d;
            glitch_count_q <= glitch_count_d;
        end
    end

    assign short_count  = short_count_q;
    assign long_count   = long_count_q;
    assign glitch_count = glitch_count_q;
`else
    logic unused_cnt;
    assign unused_cnt   = ^{cnt_clr, inc_short, inc_long, inc_glitch};
    assign short_count  = '0;
    assign long_count   = '0;
    assign glitch_count = '0;
`endif

endmodule

// File: tb/tb_master_reset_classifier.sv
// Self-checking bench for master_reset_classifier (default parameters): a timestamp-based
// reference model, a per-cycle compare process, directed scenarios and random stimulus.
module tb_master_reset_classifier;

    localparam int SYNC   = 2;
    localparam int MINW   = 2;
    localparam int SHORTM = 5;
    localparam int STUCKM = 1000;
    localparam int OW     = 4;
    localparam int HOLD   = 8;
`ifdef MASTER_RESET_COUNTERS_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, raw, clr;
    logic        short_reset, long_reset, stuck, busy;
    logic [9:0]  last_width;
    logic [15:0] short_count, long_count, glitch_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    master_reset_classifier dut (
        .clk            (clk),
        .rst            (rst),
        .rst_from_master(raw),
        .cnt_clr        (clr),
        .short_reset    (short_reset),
        .long_reset     (long_reset),
        .stuck          (stuck),
        .busy           (busy),
        .last_width     (last_width),
        .short_count    (short_count),
        .long_count     (long_count),
        .glitch_count   (glitch_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (event timestamps) ----------------
    int cyc = 0;
    bit m_ready = 1'b0;
    bit sm[SYNC];
    int meas_start = -1;  // edge at which the current high run was first seen
    bit m_stuck, locked, wait_low, kind_long;
    int out_end, free_at;  // edge the output pulse ends / edge the lockout is over
    int m_lw, m_sc, m_lc, m_gc;

    task automatic start_pulse(input bit lg);
        locked    = 1'b1;
        kind_long = lg;
        out_end   = cyc + OW;
        free_at   = out_end + HOLD;
    endtask

    function automatic int sat(input int v, input bit inc, input bit c);
        if (c) return 0;
        if (inc && v < 65535) return v + 1;
        return v;
    endfunction

    always @(posedge clk) begin
        bit s, is_s, is_l, is_g;
        int w;
        cyc = cyc + 1;
        if (rst) begin
            for (int i = 0; i < SYNC; i++) sm[i] = 1'b0;
            meas_start = -1;
            m_stuck = 0; locked = 0; wait_low = 0; kind_long = 0;
            out_end = 0; free_at = 0;
            m_lw = 0; m_sc = 0; m_lc = 0; m_gc = 0;
            m_ready = 1'b1;
        end else if (m_ready) begin
            s = sm[SYNC-1];
            for (int i = SYNC - 1; i > 0; i--) sm[i] = sm[i-1];
            sm[0] = raw;
            is_s = 0; is_l = 0; is_g = 0;
            if (locked) begin
                if (cyc == free_at) begin
                    locked   = 0;
                    wait_low = s;
                end
            end else if (wait_low) begin
                if (!s) wait_low = 0;
            end else if (m_stuck) begin
                if (!s) begin
                    m_stuck = 0;
                    m_lw    = STUCKM;
                    start_pulse(1'b1);
                    is_l = 1;
                end
            end else if (meas_start >= 0) begin
                if (s) begin
                    if (cyc - meas_start + 1 == STUCKM) begin
                        m_stuck    = 1;
                        meas_start = -1;
                    end
                end else begin
                    w = cyc - meas_start;
                    m_lw = w;
                    meas_start = -1;
                    if (w < MINW) is_g = 1;
                    else if (w <= SHORTM) begin start_pulse(1'b0); is_s = 1; end
                    else begin start_pulse(1'b1); is_l = 1; end
                end
            end else if (s) begin
                meas_start = cyc;
            end
            m_sc = sat(m_sc, is_s, clr);
            m_lc = sat(m_lc, is_l, clr);
            m_gc = sat(m_gc, is_g, clr);
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        if (m_ready) begin
            chk("short_reset", short_reset, locked && !kind_long && cyc < out_end);
            chk("long_reset", long_reset, m_stuck || (locked && kind_long && cyc < out_end));
            chk("stuck", stuck, m_stuck);
            chk("busy", busy, locked || wait_low || m_stuck || meas_start >= 0);
            chk("last_width", last_width, m_lw);
            chk("short_count", short_count, CntEn ? m_sc : 0);
            chk("long_count", long_count, CntEn ? m_lc : 0);
            chk("glitch_count", glitch_count, CntEn ? m_gc : 0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic r, input logic c, input int n);
        for (int i = 0; i < n; i++) begin
            raw = r;
            clr = c;
            @(posedge clk);
            #1;
        end
        clr = 1'b0;
    endtask

    // Hold raw at r for n cycles, counting output activity after each edge
    task automatic obs(input logic r, input int n, output int nsh, output int nlg,
                       output int nst, output int first);
        nsh = 0; nlg = 0; nst = 0; first = -1;
        for (int i = 0; i < n; i++) begin
            drive(r, 1'b0, 1);
            if (short_reset) nsh++;
            if (long_reset) nlg++;
            if (stuck) nst++;
            if ((short_reset || long_reset || stuck) && first < 0) first = i;
        end
    endtask

    initial begin
        int nsh, nlg, nst, first, nsh2, nlg2, nst2, first2, k;
        bit seen;
        raw = 1'b0; clr = 1'b0; rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_short", short_reset, 0);
        chk("rst_long", long_reset, 0);
        chk("rst_busy", busy, 0);
        chk("rst_lw", last_width, 0);
        drive(0, 0, 5);

        // 1-cycle glitch
        drive(1, 0, 1);
        obs(0, 20, nsh, nlg, nst, first);
        chk("glitch_no_out", nsh + nlg, 0);
        chk("glitch_cnt", glitch_count, CntEn ? 1 : 0);
        chk("glitch_busy", busy, 0);

        // 4-cycle short pulse
        drive(1, 0, 4);
        obs(0, 30, nsh, nlg, nst, first);
        chk("short_len", nsh, 4);
        chk("short_no_long", nlg, 0);
        chk("short_latency", first + 1, SYNC + 1);
        chk("short_lw", last_width, 4);
        chk("short_cnt", short_count, CntEn ? 1 : 0);

        // 20-cycle long pulse
        drive(1, 0, 20);
        obs(0, 40, nsh, nlg, nst, first);
        chk("long_len", nlg, 4);
        chk("long_no_short", nsh, 0);
        chk("long_lw", last_width, 20);
        chk("long_cnt", long_count, CntEn ? 1 : 0);

        // stuck high for 1500 cycles
        obs(1, 1500, nsh, nlg, nst, first);
        obs(0, 40, nsh2, nlg2, nst2, first2);
        chk("stuck_rise", first, SYNC + STUCKM - 1);
        chk("stuck_len", nst + nst2, 501);
        chk("stuck_long_len", nlg + nlg2, 505);
        chk("stuck_lw", last_width, STUCKM);
        chk("stuck_off", stuck, 0);
        chk("stuck_long_cnt", long_count, CntEn ? 2 : 0);

        // second pulse inside holdoff is swallowed (goes through WAIT_LOW)
        drive(1, 0, 4);
        seen = 0;
        for (k = 0; k < 30; k++) begin
            drive(0, 0, 1);
            if (short_reset) seen = 1;
            if (seen && !short_reset) break;
        end
        chk("holdoff_sync_found", k < 30, 1);
        drive(0, 0, 2);
        drive(1, 0, 4);
        obs(0, 40, nsh, nlg, nst, first);
        chk("holdoff_swallow", nsh + nlg, 0);
        drive(1, 0, 4);
        obs(0, 30, nsh, nlg, nst, first);
        chk("after_idle_short", nsh, 4);
        chk("after_idle_cnt", short_count, CntEn ? 3 : 0);

        // cnt_clr on the same edge as a short decision
        drive(1, 0, 4);
        drive(0, 0, 2);
        drive(0, 1, 1);
        chk("clr_short_out", short_reset, 1);
        chk("clr_wins", short_count, 0);
        drive(0, 0, 30);

        // rst in the middle of a long output pulse
        drive(1, 0, 20);
        drive(0, 0, 4);
        chk("pre_rst_long", long_reset, 1);
        rst = 1'b1;
        drive(0, 0, 1);
        rst = 1'b0;
        chk("mid_rst_long", long_reset, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_lw", last_width, 0);
        chk("mid_rst_lcnt", long_count, 0);

        // random stimulus
        for (int seg = 0; seg < 250; seg++) begin
            int len;
            logic r;
            r   = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 30) : $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                raw = r;
                clr = ($urandom_range(0, 24) == 0);
                rst = ($urandom_range(0, 399) == 0);
                @(posedge clk);
                #1;
            end
            rst = 1'b0;
            clr = 1'b0;
        end
        drive(0, 0, 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
